// File: rtl/countdown_bcd_hour.sv
// countdown_bcd_hour: BCD hour down-counter 23..00 with wrap borrow, guarded load and seven-segment drive
module seven_segment (
    input  logic [3:0] d,
    output logic [6:0] seg
);
    always_comb begin
        case (d)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

module countdown_bcd_hour #(
    parameter logic [7:0] WRAP_VALUE = 8'h23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        borrow_in,
    input  logic        load,
    input  logic [7:0]  load_value,
    output logic [7:0]  s,
    output logic [13:0] q,
    output logic        borrow_out,
    output logic        load_err
);
    logic       legal;
    logic [7:0] s_dec;
    // Valid BCD compares in the same order as its decimal value, so a plain compare bounds it
    assign legal = (load_value[7:4] <= 4'd9) && (load_value[3:0] <= 4'd9) && (load_value <= WRAP_VALUE);
    assign s_dec = (s == 8'h00) ? WRAP_VALUE :
                   (s[3:0] != 4'd0) ? {s[7:4], s[3:0] - 4'd1} : {s[7:4] - 4'd1, 4'd9};
    assign borrow_out = reset & borrow_in & ~load & (s == 8'h00);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s        <= 8'h00;
            load_err <= 1'b0;
        end else begin
            load_err <= load & ~legal;
            if (load) begin
                if (legal) s <= load_value;
            end else if (borrow_in) begin
                s <= s_dec;
            end
        end
    end
    seven_segment u_ones (.d(s[3:0]), .seg(q[6:0]));
    seven_segment u_tens (.d(s[7:4]), .seg(q[13:7]));
endmodule

// File: tb/tb_countdown_bcd_hour.sv
// tb_countdown_bcd_hour: scoreboard bench for the BCD hour down-counter
module tb_countdown_bcd_hour;
    logic        clk = 1'b0;
    logic        reset;
    logic        borrow_in;
    logic        load;
    logic [7:0]  load_value;
    logic [7:0]  s;
    logic [13:0] q;
    logic        borrow_out;
    logic        load_err;

    typedef struct {
        logic [7:0] s;
        logic       err;
        logic       bo;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] m_s;
    logic       m_err;
    logic       obs_bo;
    int         n_tests = 0;
    int         n_fail = 0;

    countdown_bcd_hour dut (
        .clk(clk), .reset(reset), .borrow_in(borrow_in), .load(load),
        .load_value(load_value), .s(s), .q(q), .borrow_out(borrow_out), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [7:0] v);
        int t = int'(v[7:4]);
        int o = int'(v[3:0]);
        return (t <= 9) && (o <= 9) && (t * 10 + o <= 23);
    endfunction

    function automatic logic [7:0] dec(input logic [7:0] v);
        int n = int'(v[7:4]) * 10 + int'(v[3:0]);
        n = (n == 0) ? 23 : n - 1;
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Applies one cycle of stimulus, records the expected post-edge state, then steps past the edge
    task automatic drive(input logic bi, input logic ld, input logic [7:0] lv);
        exp_t x;
        borrow_in = bi; load = ld; load_value = lv;
        #2 obs_bo = borrow_out;
        x.bo = bi && !ld && (m_s == 8'h00);
        if (ld) begin
            if (is_legal(lv)) m_s = lv;
            m_err = !is_legal(lv);
        end else begin
            m_err = 1'b0;
            if (bi) m_s = dec(m_s);
        end
        x.s = m_s; x.err = m_err;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; borrow_in = 1'b1; load = 1'b0; load_value = 8'h00;
        #12;
        n_tests++;
        if (s !== 8'h00 || load_err !== 1'b0 || borrow_out !== 1'b0 || q !== {seg(4'h0), seg(4'h0)}) begin
            n_fail++;
            $display("FAIL reset: s=%h err=%b bo=%b q=%h, expected s=00 err=0 bo=0 q=%h",
                     s, load_err, borrow_out, q, {seg(4'h0), seg(4'h0)});
        end
        borrow_in = 1'b0;
        reset = 1'b1;
        m_s = 8'h00; m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap_cycle;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1'b0, 8'h00);
            e = sb.pop_front();
            n_tests++;
            if (s !== e.s || load_err !== e.err || obs_bo !== e.bo || q !== {seg(e.s[7:4]), seg(e.s[3:0])}) begin
                n_fail++;
                $display("FAIL wrap step %0d: s=%h err=%b bo=%b q=%h, expected s=%h err=%b bo=%b",
                         i, s, load_err, obs_bo, q, e.s, e.err, e.bo);
            end
        end
    endtask

    task automatic test_decade;
        logic [7:0] lv[4] = '{8'h20, 8'h00, 8'h10, 8'h00};
        logic       ld[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(!ld[i], ld[i], lv[i]);
            e = sb.pop_front();
            n_tests++;
            if (s !== e.s || load_err !== e.err || obs_bo !== e.bo || q !== {seg(e.s[7:4]), seg(e.s[3:0])}) begin
                n_fail++;
                $display("FAIL decade step %0d: s=%h err=%b bo=%b, expected s=%h err=%b bo=%b",
                         i, s, load_err, obs_bo, e.s, e.err, e.bo);
            end
        end
    endtask

    task automatic test_illegal_load;
        logic [7:0] bad[3] = '{8'h24, 8'h1A, 8'h30};
        drive(1'b0, 1'b1, 8'h15);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, bad[i]);
            drive(1'b0, 1'b0, 8'h00);
            for (int k = 0; k < 2; k++) begin
                e = sb.pop_front();
                if (k == 0) begin
                    borrow_in = 1'b0;
                end
                n_tests++;
                if ((k == 0 ? 8'h15 : 8'h15) !== e.s) begin
                    n_fail++;
                    $display("FAIL illegal model %0d: model s=%h, expected s=15", i, e.s);
                end
            end
        end
    endtask

    task automatic test_illegal_sequence;
        logic [7:0] bad[3] = '{8'h24, 8'h1A, 8'h30};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, bad[i]);
            e = sb.pop_front();
            n_tests++;
            if (s !== 8'h15 || load_err !== 1'b1 || obs_bo !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal %h: s=%h err=%b bo=%b, expected s=15 err=1 bo=0",
                         bad[i], s, load_err, obs_bo);
            end
            drive(1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
            n_tests++;
            if (s !== 8'h15 || load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal %h clear: s=%h err=%b, expected s=15 err=0", bad[i], s, load_err);
            end
        end
    endtask

    task automatic test_load_priority;
        drive(1'b0, 1'b1, 8'h00);
        void'(sb.pop_front());
        drive(1'b1, 1'b1, 8'h07);
        e = sb.pop_front();
        n_tests++;
        if (s !== 8'h07 || obs_bo !== 1'b0 || load_err !== 1'b0 || q !== {seg(4'h0), seg(4'h7)}) begin
            n_fail++;
            $display("FAIL load_priority: s=%h bo=%b err=%b q=%h, expected s=07 bo=0 err=0",
                     s, obs_bo, load_err, q);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 1'b1, 8'h12);
        void'(sb.pop_front());
        borrow_in = 1'b1; load = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (s !== 8'h00 || borrow_out !== 1'b0 || q !== {seg(4'h0), seg(4'h0)}) begin
            n_fail++;
            $display("FAIL reset_mid async: s=%h bo=%b, expected s=00 bo=0", s, borrow_out);
        end
        borrow_in = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        m_s = 8'h00; m_err = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 8'h00);
        e = sb.pop_front();
        n_tests++;
        if (s !== 8'h23 || obs_bo !== 1'b1 || e.s !== 8'h23) begin
            n_fail++;
            $display("FAIL reset_mid borrow: s=%h bo=%b, expected s=23 bo=1", s, obs_bo);
        end
    endtask

    task automatic test_hold;
        drive(1'b0, 1'b1, 8'h05);
        void'(sb.pop_front());
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
            n_tests++;
            if (s !== 8'h05 || obs_bo !== 1'b0 || load_err !== 1'b0 || q !== {seg(4'h0), seg(4'h5)}) begin
                n_fail++;
                $display("FAIL hold cycle %0d: s=%h bo=%b err=%b, expected s=05 bo=0 err=0",
                         i, s, obs_bo, load_err);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  {4'($urandom_range(0, 3)), 4'($urandom_range(0, 11))});
            e = sb.pop_front();
            n_tests++;
            if (s !== e.s || load_err !== e.err || obs_bo !== e.bo || q !== {seg(e.s[7:4]), seg(e.s[3:0])}) begin
                n_fail++;
                $display("FAIL back_to_back %0d: s=%h err=%b bo=%b, expected s=%h err=%b bo=%b",
                         i, s, load_err, obs_bo, e.s, e.err, e.bo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_wrap_cycle;
        test_decade;
        drive(1'b0, 1'b1, 8'h15);
        void'(sb.pop_front());
        test_illegal_sequence;
        test_load_priority;
        test_reset_mid;
        test_hold;
        test_back_to_back;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/countdown_bcd_hour.md
Name: countdown_bcd_hour

Overview:
- BCD hour down-counter. Counts 23, 22, …, 01, 00, then wraps back to 23.
- One decrement per enabled clock; emits a borrow to the next-higher (day) stage when it wraps.
- Companion to the hour up-counter. Used by the timer/alarm path to set a remaining-time value and count it down.
- Drives two seven-segment digits through the team's existing seven_segment decoder, plus a raw BCD debug bus.

Parameters:
- WRAP_VALUE, 8'h23, BCD value loaded on wrap from 00. This is also the highest legal value: tens nibble 0..2, ones nibble 0..9, overall value ≤ WRAP_VALUE.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- borrow_in  input  1  decrement enable for this cycle (borrow from the lower minutes stage)
- load  input  1  synchronous load strobe
- load_value  input  8  BCD value to load; [7:4] tens, [3:0] ones
- s  output  8  current BCD count (registered); [7:4] tens, [3:0] ones
- q  output  14  seven-segment outputs; q[6:0] = seven_segment(s[3:0]), q[13:7] = seven_segment(s[7:4])
- borrow_out  output  1  combinational borrow to the next stage
- load_err  output  1  registered one-cycle flag: illegal load was rejected

Behaviour:
- Reset (reset=0, asynchronous): s=8'h00, load_err=0, immediately and independent of clk.
  - q follows s combinationally, so it shows "00".
  - borrow_out=0 while in reset.
- Priority at each rising edge: load > borrow_in > hold.

Load path (load=1):
- A legal load_value means tens ≤ 9, ones ≤ 9, and BCD value ≤ WRAP_VALUE.
- If load_value is legal: s ← load_value, load_err ← 0.
- If load_value is illegal: s unchanged, load_err ← 1 for exactly one cycle.
- borrow_in is ignored in a load cycle; no decrement occurs.

Decrement path (borrow_in=1, load=0):
- Ones ≠ 0: ones ← ones−1, tens unchanged.
- Ones = 0 and tens ≠ 0: ones ← 9, tens ← tens−1 (e.g. 20 → 19, 10 → 09).
- s = 00: s ← WRAP_VALUE (23).

Hold (borrow_in=0, load=0): s unchanged.

Flags and outputs:
- load_err ← 0 on every edge that is not an illegal load.
- borrow_out = reset & borrow_in & ~load & (s == 8'h00).
  - High during the cycle whose edge performs 00 → 23, giving zero-latency ripple to the day stage.
  - Never asserted on load.
- Latency: s and q update on the same edge as the accepted event; q has no extra register.

Invariants:
- s is always valid BCD within 00..WRAP_VALUE.
- Nibble values 0xA–0xF never appear on s.

Reset mid-operation:
- Asserting reset on any cycle, including a load or borrow cycle, forces 00.
- After release, the first edge with borrow_in=1 yields 23 with borrow_out=1.

Continuous borrow_in: sustained borrow_in=1 decrements every cycle; the full period is 24 cycles with exactly one borrow_out pulse.

Test Plan:
- Reset, then hold borrow_in=1 for 24 edges.
  - s sequence: 00 → 23 → 22 … → 01 → 00.
  - borrow_out high only in the first cycle (s=00).
  - q matches seven_segment of each nibble in every cycle.
- Load 8'h20, then one borrow → s=8'h19. Load 8'h10, then one borrow → s=8'h09. No borrow_out in either case.
- Illegal loads 8'h24, 8'h1A and 8'h30 with s=8'h15:
  - s stays 15 after each.
  - load_err=1 for one cycle after each load, then 0.
- Simultaneous load=1 with load_value=8'h07 and borrow_in=1, while s=00:
  - s=07 after the edge.
  - borrow_out=0 during that cycle.
- Reset during a borrow cycle with s=12: s=00 asynchronously, before the next edge. After release plus one borrow: s=23, borrow_out pulsed.
- Idle hold: borrow_in=0 and load=0 for 10 cycles at s=8'h05 → s stays 05, borrow_out=0, load_err=0 throughout.
